// File: rtl/cam_match_if.sv
// cam_match_if: write/delete, clear-sweep and search bus of the CAM match array.
// Optional feature macro: CAM_MASK_EN adds the per-bit search_mask signal.
interface cam_match_if #(
    parameter int DEPTH     = 16,
    parameter int KEY_WIDTH = 32
);
    localparam int AW = $clog2(DEPTH);
    logic                 wr_en;
    logic                 del_en;
    logic [AW-1:0]        wr_addr;
    logic [KEY_WIDTH-1:0] wr_key;
    logic                 clr_start;
    logic                 busy;
    logic                 search_en;
    logic [KEY_WIDTH-1:0] search_key;
`ifdef CAM_MASK_EN
    logic [KEY_WIDTH-1:0] search_mask;
`endif
    logic                 match_valid;
    logic [DEPTH-1:0]     match_lines;
    logic [AW:0]          entry_count;
    logic                 full;

    modport master (
`ifdef CAM_MASK_EN
        output search_mask,
`endif
        output wr_en, del_en, wr_addr, wr_key, clr_start, search_en, search_key,
        input  busy, match_valid, match_lines, entry_count, full
    );

    modport slave (
`ifdef CAM_MASK_EN
        input  search_mask,
`endif
        input  wr_en, del_en, wr_addr, wr_key, clr_start, search_en, search_key,
        output busy, match_valid, match_lines, entry_count, full
    );
endinterface

// File: rtl/cam_match_array.sv
// cam_match_array: CAM key storage with valid bits, registered match vector, clear sweep and occupancy.
// Optional feature macro: CAM_MASK_EN enables ternary (masked) compare via search_mask.
module cam_match_array #(
    parameter int DEPTH     = 16,
    parameter int KEY_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    cam_match_if.slave  cam
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t               state_q;
    logic [AW-1:0]        ptr_q;
    logic                 busy_q;
    logic [DEPTH-1:0]     valid_q, valid_d, hit, match_lines_q;
    logic [KEY_WIDTH-1:0] key_q [DEPTH];
    logic                 match_valid_q, full_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 idle, clr_go, wr_go, del_go, srch_go;

    // A clear request pre-empts every other operation issued in the same cycle.
    assign idle    = (state_q == IDLE);
    assign clr_go  = idle & cam.clr_start;
    assign del_go  = idle & ~cam.clr_start & cam.del_en;
    assign wr_go   = idle & ~cam.clr_start & cam.wr_en & ~cam.del_en;
    assign srch_go = idle & ~cam.clr_start & cam.search_en;

    // Per-entry compare against the pre-update contents.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef CAM_MASK_EN
            hit[i] = valid_q[i] & ~|((key_q[i] ^ cam.search_key) & cam.search_mask);
`else
            hit[i] = valid_q[i] & (key_q[i] == cam.search_key);
`endif
        end
    end

    // Next valid vector and occupancy: sweep clears first, then delete beats write.
    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        if (!idle) begin
            valid_d[ptr_q] = 1'b0;
            count_d        = count_q - CW'(valid_q[ptr_q]);
        end else if (del_go) begin
            valid_d[cam.wr_addr] = 1'b0;
            count_d              = count_q - CW'(valid_q[cam.wr_addr]);
        end else if (wr_go) begin
            valid_d[cam.wr_addr] = 1'b1;
            count_d              = count_q + CW'(!valid_q[cam.wr_addr]);
        end
    end

    // Clear-sweep FSM: walks ptr over every entry once, busy while in CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (clr_go) begin
                    state_q <= CLEAR;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                end
                CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == AW'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage, occupancy and the registered search result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            match_valid_q <= 1'b0;
            match_lines_q <= '0;
            for (int i = 0; i < DEPTH; i++) key_q[i] <= '0;
        end else begin
            valid_q       <= valid_d;
            count_q       <= count_d;
            full_q        <= (count_d == CW'(DEPTH));
            match_valid_q <= srch_go;
            if (srch_go) match_lines_q <= hit;
            if (wr_go) key_q[cam.wr_addr] <= cam.wr_key;
        end
    end

    assign cam.busy        = busy_q;
    assign cam.match_valid = match_valid_q;
    assign cam.match_lines = match_lines_q;
    assign cam.entry_count = count_q;
    assign cam.full        = full_q;
endmodule

// File: tb/tb_cam_match_array.sv
// tb_cam_match_array: directed scoreboard bench for cam_match_array (DEPTH=16, KEY_WIDTH=32).
module tb_cam_match_array;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cam_match_if #(.DEPTH(16), .KEY_WIDTH(32)) cam();
    cam_match_array #(.DEPTH(16), .KEY_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .cam(cam));

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q [$];
    logic [15:0] last_exp = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        cam.wr_en = 0; cam.del_en = 0; cam.wr_addr = '0; cam.wr_key = '0;
        cam.clr_start = 0; cam.search_en = 0; cam.search_key = '0;
`ifdef CAM_MASK_EN
        cam.search_mask = '1;
`endif
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] k);
        cam.wr_en = 1; cam.wr_addr = a; cam.wr_key = k;
        step();
        cam.wr_en = 0;
    endtask

    task automatic del(input logic [3:0] a);
        cam.del_en = 1; cam.wr_addr = a;
        step();
        cam.del_en = 0;
    endtask

    task automatic pop_chk(input string tag);
        chk({tag, "_mv"}, 64'(cam.match_valid), 64'd1);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb observed=result expected=no_pending_search", tag);
        end else begin
            last_exp = exp_q.pop_front();
            chk({tag, "_lines"}, 64'(cam.match_lines), 64'(last_exp));
        end
    endtask

    task automatic srch(input string tag, input logic [31:0] k, input logic [15:0] e);
        cam.search_en = 1; cam.search_key = k;
        exp_q.push_back(e);
        step();
        cam.search_en = 0;
        pop_chk(tag);
    endtask

    initial begin
        int n;
        int idx;
        quiet();
        #12;
        chk("rst_busy", 64'(cam.busy), 0);
        chk("rst_mv", 64'(cam.match_valid), 0);
        chk("rst_lines", 64'(cam.match_lines), 0);
        chk("rst_count", 64'(cam.entry_count), 0);
        chk("rst_full", 64'(cam.full), 0);
        rst_n = 1;
        step();
        // 1: empty CAM
        srch("t1", 32'h0, 16'h0000);
        chk("t1_count", 64'(cam.entry_count), 0);
        step();
        chk("t1_mv_drop", 64'(cam.match_valid), 0);
        chk("t1_hold", 64'(cam.match_lines), 64'(last_exp));
        // 2: single match
        wr(3, 32'hDEAD0001);
        wr(7, 32'hBEEF0002);
        srch("t2", 32'hBEEF0002, 16'h0080);
        chk("t2_count", 64'(cam.entry_count), 2);
        // 3: multi-hit
        wr(2, 32'h12345678);
        wr(9, 32'h12345678);
        srch("t3", 32'h12345678, 16'h0204);
        idx = -1;
        for (int i = 15; i >= 0; i--) if (cam.match_lines[i]) idx = i;
        chk("t3_enc", 64'(idx), 2);
        chk("t3_count", 64'(cam.entry_count), 4);
        // 4: read-before-write
        cam.wr_en = 1; cam.wr_addr = 5; cam.wr_key = 32'hAAAA0000;
        cam.search_en = 1; cam.search_key = 32'hAAAA0000;
        exp_q.push_back(16'h0000);
        step();
        quiet();
        pop_chk("t4a");
        srch("t4b", 32'hAAAA0000, 16'h0020);
        chk("t4_count", 64'(cam.entry_count), 5);
        wr(5, 32'hAAAA0000);
        chk("ovw_count", 64'(cam.entry_count), 5);
        del(0);
        chk("del_inv_count", 64'(cam.entry_count), 5);
        del(3);
        chk("del_count", 64'(cam.entry_count), 4);
        srch("del_srch", 32'hDEAD0001, 16'h0000);
        // 5: fill, back-to-back, clear sweep
        for (int i = 0; i < 16; i++) wr(4'(i), 32'h100 + i);
        chk("fill_count", 64'(cam.entry_count), 16);
        chk("fill_full", 64'(cam.full), 1);
        cam.search_en = 1; cam.search_key = 32'h100;
        exp_q.push_back(16'h0001);
        step();
        pop_chk("b2b_a");
        cam.search_key = 32'h10F;
        exp_q.push_back(16'h8000);
        step();
        pop_chk("b2b_b");
        cam.clr_start = 1;
        cam.wr_en = 1; cam.wr_addr = 0; cam.wr_key = 32'h999;
        cam.search_key = 32'h100;
        step();
        cam.clr_start = 0;
        cam.wr_addr = 1; cam.wr_key = 32'h777; cam.search_key = 32'h777;
        chk("clr_busy", 64'(cam.busy), 1);
        n = 0;
        while (cam.busy && n < 40) begin
            chk("busy_mv", 64'(cam.match_valid), 0);
            n++;
            step();
        end
        quiet();
        chk("sweep_len", 64'(n), 16);
        chk("sweep_busy", 64'(cam.busy), 0);
        chk("sweep_mv", 64'(cam.match_valid), 0);
        chk("sweep_count", 64'(cam.entry_count), 0);
        chk("sweep_full", 64'(cam.full), 0);
        srch("sweep_wr_drop", 32'h777, 16'h0000);
        srch("sweep_clr_drop", 32'h999, 16'h0000);
        srch("sweep_old", 32'h100, 16'h0000);
        // 6: write and delete together
        cam.wr_en = 1; cam.del_en = 1; cam.wr_addr = 4; cam.wr_key = 32'h44;
        step();
        quiet();
        chk("wd_inv_count", 64'(cam.entry_count), 0);
        srch("wd_inv", 32'h44, 16'h0000);
        wr(4, 32'h55);
        chk("wd_pre_count", 64'(cam.entry_count), 1);
        cam.wr_en = 1; cam.del_en = 1; cam.wr_addr = 4; cam.wr_key = 32'h55;
        step();
        quiet();
        chk("wd_val_count", 64'(cam.entry_count), 0);
        srch("wd_val", 32'h55, 16'h0000);
`ifdef CAM_MASK_EN
        wr(6, 32'h1234ABCD);
        cam.search_mask = 32'hFFFF0000;
        srch("mask_hi", 32'h12340000, 16'h0040);
        cam.search_mask = 32'h0;
        srch("mask_zero", 32'hFFFFFFFF, 16'h0040);
        cam.search_mask = '1;
        srch("mask_full", 32'h12340000, 16'h0000);
        del(6);
`endif
        // reset in the middle of a sweep
        wr(0, 32'h1);
        wr(1, 32'h2);
        cam.clr_start = 1;
        step();
        cam.clr_start = 0;
        step();
        #2 rst_n = 0;
        #1;
        chk("mrst_busy", 64'(cam.busy), 0);
        chk("mrst_count", 64'(cam.entry_count), 0);
        rst_n = 1;
        step();
        srch("mrst_e1", 32'h2, 16'h0000);
        chk("mrst_idle", 64'(cam.busy), 0);
        chk("sb_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
